// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the transfer byte-lane decode used by the SRAM controller.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    // An all-zero mask marks the transfer as illegal (misaligned or oversized).
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[0] ? 4'b0000 : (addr[1] ? 4'b1100 : 4'b0011);
            HSIZE_WORD: m = (addr == 2'b00) ? 4'b1111 : 4'b0000;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahbl_sram_ctrl_chk.sv
// Invariant checks for the SRAM controller port arbitration.
module ahbl_sram_ctrl_chk (
    input logic clk,
    input logic rst_n,
    input logic rd_now,
    input logic wr_phase,
    input logic buf_valid
);

    // A write parked behind a read must never find an undrained entry in the buffer.
    a_no_buf_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_now && wr_phase && buf_valid));

endmodule

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted-write buffer with byte-lane merge into read data for
// read-after-write coherence.
module ahbl_sram_wbuf
    import ahbl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] load_addr,
    input  logic [3:0]    load_mask,
    input  logic [31:0]   load_data,
    input  logic          rd_active,
    input  logic [AW-1:0] rd_addr,
    input  logic [31:0]   sram_rdata,
    output logic          buf_valid,
    output logic [AW-1:0] buf_addr,
    output logic [3:0]    buf_mask,
    output logic [31:0]   buf_data,
    output logic [31:0]   rdata
);

    logic          valid_r;
    logic [AW-1:0] addr_r;
    logic [3:0]    mask_r;
    logic [31:0]   data_r;
    logic          hit_s;
    logic [31:0]   merged_s;

    // Buffer entry: a load always wins over a clear so a drain-and-refill keeps it valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            mask_r  <= 4'b0000;
            data_r  <= 32'h0000_0000;
        end else if (load) begin
            valid_r <= 1'b1;
            addr_r  <= load_addr;
            mask_r  <= load_mask;
            data_r  <= load_data;
        end else if (clear) begin
            valid_r <= 1'b0;
        end
    end

    assign hit_s = valid_r && (addr_r == rd_addr);

    // Per-lane merge of buffered bytes over the RAM output during a read data phase.
    always_comb begin
        merged_s = 32'h0000_0000;
        if (rd_active) begin
            for (int i = 0; i < 4; i++) begin
                if (hit_s && mask_r[i]) begin
                    merged_s[8*i +: 8] = data_r[8*i +: 8];
                end else begin
                    merged_s[8*i +: 8] = sram_rdata[8*i +: 8];
                end
            end
        end else begin
            merged_s = 32'h0000_0000;
        end
    end

    assign buf_valid = valid_r;
    assign buf_addr  = addr_r;
    assign buf_mask  = mask_r;
    assign buf_data  = data_r;
    assign rdata     = merged_s;

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave front end for a single-port synchronous SRAM: zero-wait reads and
// writes via a one-entry write buffer, two-cycle ERROR for illegal transfers.
module ahbl_sram_ctrl
    import ahbl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-1:0] SRAMADDR
);

    logic          accept_s;
    logic [3:0]    mask_s;
    logic          legal_s;
    logic          rd_now_s;
    logic          wr_now_s;
    logic          err_now_s;

    err_state_e    state_r;
    err_state_e    state_s;
    logic          hreadyout_r;
    logic          hresp_r;

    logic          rd_phase_r;
    logic          wr_phase_r;
    logic [AW-1:0] dp_addr_r;
    logic [3:0]    dp_mask_r;

    logic          cs_s;
    logic [3:0]    wen_s;
    logic [AW-1:0] addr_s;
    logic [31:0]   wdata_s;
    logic          buf_load_s;
    logic          buf_clear_s;

    logic          buf_valid_s;
    logic [AW-1:0] buf_addr_s;
    logic [3:0]    buf_mask_s;
    logic [31:0]   buf_data_s;

    logic          unused_s;

    assign accept_s  = HSEL & HREADY & HTRANS[1];
    assign mask_s    = byte_mask(HSIZE, HADDR[1:0]);
    assign legal_s   = (mask_s != 4'b0000);
    assign rd_now_s  = accept_s & legal_s & ~HWRITE;
    assign wr_now_s  = accept_s & legal_s & HWRITE;
    assign err_now_s = accept_s & ~legal_s;
    assign unused_s  = ^{HADDR[31:AW+2], HTRANS[0]};

    // Error response sequencer next state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_OK:   state_s = err_now_s ? ST_ERR1 : ST_OK;
            ST_ERR1: state_s = ST_ERR2;
            ST_ERR2: state_s = err_now_s ? ST_ERR1 : ST_OK;
            default: state_s = ST_OK;
        endcase
    end

    // Error state and registered handshake outputs.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r     <= ST_OK;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_s;
            hreadyout_r <= (state_s != ST_ERR1);
            hresp_r     <= (state_s != ST_OK) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    // Data-phase context captured from each completed address phase.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rd_phase_r <= 1'b0;
            wr_phase_r <= 1'b0;
            dp_addr_r  <= '0;
            dp_mask_r  <= 4'b0000;
        end else if (HREADY) begin
            rd_phase_r <= rd_now_s;
            wr_phase_r <= wr_now_s;
            dp_addr_r  <= HADDR[AW+1:2];
            dp_mask_r  <= mask_s;
        end
    end

    // SRAM port arbitration; the port is kept quiet while reset is asserted so a
    // pending buffered write is discarded rather than drained.
    always_comb begin
        cs_s        = 1'b0;
        wen_s       = 4'b0000;
        addr_s      = '0;
        wdata_s     = 32'h0000_0000;
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        if (!HRESETn) begin
            cs_s = 1'b0;
        end else if (rd_now_s) begin
            cs_s       = 1'b1;
            addr_s     = HADDR[AW+1:2];
            buf_load_s = wr_phase_r;
        end else if (wr_phase_r && !buf_valid_s) begin
            cs_s    = 1'b1;
            wen_s   = dp_mask_r;
            addr_s  = dp_addr_r;
            wdata_s = HWDATA;
        end else if (wr_phase_r) begin
            cs_s       = 1'b1;
            wen_s      = buf_mask_s;
            addr_s     = buf_addr_s;
            wdata_s    = buf_data_s;
            buf_load_s = 1'b1;
        end else if (buf_valid_s) begin
            cs_s        = 1'b1;
            wen_s       = buf_mask_s;
            addr_s      = buf_addr_s;
            wdata_s     = buf_data_s;
            buf_clear_s = 1'b1;
        end else begin
            cs_s = 1'b0;
        end
    end

    ahbl_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .load       (buf_load_s),
        .clear      (buf_clear_s),
        .load_addr  (dp_addr_r),
        .load_mask  (dp_mask_r),
        .load_data  (HWDATA),
        .rd_active  (rd_phase_r),
        .rd_addr    (dp_addr_r),
        .sram_rdata (SRAMRDATA),
        .buf_valid  (buf_valid_s),
        .buf_addr   (buf_addr_s),
        .buf_mask   (buf_mask_s),
        .buf_data   (buf_data_s),
        .rdata      (HRDATA)
    );

    ahbl_sram_ctrl_chk u_chk (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .rd_now    (rd_now_s),
        .wr_phase  (wr_phase_r),
        .buf_valid (buf_valid_s)
    );

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign SRAMCS0   = cs_s;
    assign SRAMWEN   = wen_s;
    assign SRAMADDR  = addr_s;
    assign SRAMWDATA = wdata_s;

endmodule
